// File: rtl/debounce_pkg.sv
// Shared types and constants for the two-bit input debouncer.
// Per-bit FSM states, default debounce depth and the counter-width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE = 2'd0,
        CHECK  = 2'd1,
        PEND   = 2'd2
    } db_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_debounce_2b_bit.sv
// One debounced bit: 2-flop synchroniser plus mismatch counter FSM; latency N+1+D edges.
// No backpressure; o_ready asks the top to commit, PEND exists only with DEBOUNCE_PAIR_ALIGN_EN.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_cur,
    input  logic i_commit,
    output logic o_ready,
    output logic o_busy
);

    logic             r_s1;
    logic             r_s2;
    db_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    db_state_e        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_mismatch;
    logic             w_at_limit;

    assign w_mismatch = r_s2 ^ i_cur;
    assign w_at_limit = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Ready: the D-th mismatch edge, or a parked bit that still mismatches.
    assign o_ready = w_mismatch && ((r_state == PEND) || ((r_state == CHECK) && w_at_limit));
    // Busy: still counting after this edge, so the other bit must not commit yet.
    assign o_busy  = w_mismatch && (r_state == CHECK) && !w_at_limit;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            STABLE: begin
                if (w_mismatch) begin
                    w_state_nxt = CHECK;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            CHECK: begin
                if (!w_mismatch) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (w_at_limit) begin
                    if (i_commit) begin
                        w_state_nxt = STABLE;
                        w_cnt_nxt   = '0;
                    end
`ifdef DEBOUNCE_PAIR_ALIGN_EN
                    else begin
                        w_state_nxt = PEND;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef DEBOUNCE_PAIR_ALIGN_EN
            PEND: begin
                if (!w_mismatch || i_commit) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= STABLE;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/input_debounce_2b.sv
// Two-bit synchronise+debounce front end with one-cycle change strobe; latency N+1+D edges, no backpressure.
// DEBOUNCE_PAIR_ALIGN_EN: qualified bits wait for the other bit to finish counting and commit together.
module input_debounce_2b
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_raw_in,
    output logic [1:0] o_data_out,
    output logic       o_chg
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
`ifdef DEBOUNCE_PAIR_ALIGN_EN
    localparam bit PAIR_ALIGN = 1'b1;
`else
    localparam bit PAIR_ALIGN = 1'b0;
`endif

    logic [1:0] r_data_out;
    logic       r_chg;
    logic [1:0] w_ready;
    logic [1:0] w_busy;
    logic [1:0] w_commit;

    for (genvar g = 0; g < 2; g++) begin : g_bit
        // With alignment, a ready bit holds while the other bit is still counting.
        assign w_commit[g] = w_ready[g] && !(PAIR_ALIGN && w_busy[1-g]);

        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_raw    (i_raw_in[g]),
            .i_cur    (r_data_out[g]),
            .i_commit (w_commit[g]),
            .o_ready  (w_ready[g]),
            .o_busy   (w_busy[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_data_out <= 2'b00;
            r_chg      <= 1'b0;
        end else begin
            r_data_out <= r_data_out ^ w_commit;
            r_chg      <= |w_commit;
        end
    end

    assign o_data_out = r_data_out;
    assign o_chg      = r_chg;

endmodule

// File: doc/input_debounce_2b.md
# input_debounce_2b

Two-bit input conditioner that sits directly upstream of the two-state Moore controller and drives its 2-bit `data_in`. It synchronises two asynchronous raw inputs, debounces each bit with a per-bit counter state machine, and presents a clean 2-bit word plus a one-cycle change strobe. Downstream logic therefore never sees metastable values or bounce glitches.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive mismatch cycles required to accept a new level; legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width; derived, not overridden.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `raw_in` input, 2: asynchronous raw inputs (switches or pins).
- `data_out` output, 2: debounced word; connects to the downstream FSM `data_in`.
- `chg` output, 1: one-cycle pulse in the cycle `data_out` changes.

## Operation
- Synchroniser: two flops per bit, `raw_in` → `s1` → `s2`. Only `s2` is used downstream of the synchroniser.
- Per-bit FSM states:
  - STABLE: `s2 == data_out[i]`; counter = 0. Mismatch → CHECK with counter = 1.
  - CHECK: on each edge with mismatch, counter increments. On the D-th consecutive mismatch edge (counter == D-1 and mismatch), the bit qualifies: `data_out[i]` flips and the FSM returns to STABLE with counter = 0.
  - Any match edge while in CHECK → STABLE, counter = 0, no output change. A single-cycle glitch therefore restarts the count.
- `chg` = 1 for exactly the cycle following any edge at which `data_out` changed. Two bits flipping on the same edge produce one pulse.
- Reset: asserting `rst` low clears everything immediately, regardless of clock, including mid-CHECK.
  - `s1`, `s2`, `data_out`, `chg`, and counters all go to 0.
  - All FSMs go to STABLE.
  - After deassertion, a raw input held at 1 takes the full latency to appear.
- Counter never exceeds D-1 and never wraps.

## Timing
- Latency: a raw level first sampled into `s1` at edge N, and held, appears on `data_out` at edge N+1+D. With D=4, sampled at edge 10 → `data_out` updates at edge 15 and `chg` is high in the following cycle.
- Both bits are independent. Simultaneous qualification on the same edge updates both bits on that edge.
- No input handshake. The output is a registered level, valid every cycle after reset.

## Configuration
- `DEBOUNCE_PAIR_ALIGN_EN` defined:
  - Adds a PEND state. A qualified bit enters PEND (counter held, output unchanged) while the other bit is in CHECK.
  - All PEND bits commit together on the first edge at which no bit is in CHECK.
  - A PEND bit whose `s2` returns to match `data_out` before commit goes to STABLE with no change.
  - Purpose: a 00→11 transition never shows 01 or 10 transients to the downstream FSM.
- `DEBOUNCE_PAIR_ALIGN_EN` undefined: PEND does not exist; bits commit independently as described under Operation.

## Structure
- Shared package `debounce_pkg` holds:
  - the state enum (STABLE, CHECK, PEND);
  - the default `DEBOUNCE_CYCLES` constant;
  - a `clog2`-based width helper.
- Sub-module `debounce_bit`, instantiated twice, contains:
  - the synchroniser, counter, and FSM for one bit;
  - a `qualify` output and a `commit` input, used by the top for pair alignment.
- The top owns `data_out`, `chg`, and the commit logic.

## Test plan
- Reset: hold `rst`=0 with `raw_in`=11 → `data_out`=00, `chg`=0. Release at edge 0 → `data_out`=11 at edge 1+1+4=6 (`s1` samples at edge 1), one `chg` pulse.
- Bounce: D=4, `raw_in[0]` toggles 0→1 for 2 cycles, 0 for 1, then 1 held → counter restarts on the glitch; `data_out[0]` flips exactly 4 mismatch edges after the final rise; no early flip.
- Single-cycle glitch on `raw_in[1]` → `data_out` and `chg` never change.
- Async reset mid-CHECK (counter = 2): `rst` pulsed low between edges → outputs 00 immediately; counting restarts from 0 after release.
- With `DEBOUNCE_PAIR_ALIGN_EN` defined: `raw_in` 00→01 then →11 two cycles later → `data_out` goes 00→11 in one step on bit 1's qualify edge; exactly one `chg` pulse; 01 is never observed.
- Without the macro, same stimulus → `data_out` shows 01 for 2 cycles, then 11; two `chg` pulses.
